// File: rtl/invader_move_tracker_pkg.sv
// Shared constants and types for the invader formation: leg limits, position
// bounds, screen geometry, run-control states and the sequencer command word.
package invader_move_tracker_pkg;

    // Default prescaler divide: 10 Hz move tick at 25 MHz
    localparam int unsigned TICK_DIV_DEFAULT = 2_500_000;

    // Step counter and leg limits
    localparam int unsigned CNT_W = 9;
    localparam int unsigned LIM1  = 250;
    localparam int unsigned LIM2  = 300;
    localparam int unsigned LIM3  = 250;

    // Formation position
    localparam int unsigned X_W     = 10;
    localparam int unsigned Y_W     = 10;
    localparam int unsigned X_START = 320;
    localparam int unsigned Y_START = 40;
    localparam int unsigned X_MIN   = 0;
    localparam int unsigned X_MAX   = 639;
    localparam int unsigned DROP    = 16;
    localparam int unsigned Y_LIMIT = 400;

    // Screen geometry used by the renderer
    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    // Run-control states
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_DONE  = 2'd2
    } run_state_e;

    // One-cycle command word from the movement sequencer
    typedef struct packed {
        logic sm;       // step right
        logic rs;       // step left
        logic rst_mov;  // leg complete: clear counter, drop one row
    } move_cmd_t;

    // Saturating increment of the step counter
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/invader_move_tracker_if.sv
// Sequencer <-> tracker bus.
//   master (sequencer): drives en, Sm, Rs, RstMov; reads tick, flags, position
//   slave  (tracker)  : the reverse
interface invader_move_tracker_if;
    import invader_move_tracker_pkg::*;

    logic           en;
    logic           Sm;
    logic           Rs;
    logic           RstMov;
    logic           mueva;
    logic           M1;
    logic           M2;
    logic           M3;
    logic [X_W-1:0] posx;
    logic [Y_W-1:0] posy;
    logic           invaded;
    logic           proto_err;

    modport master (
        output en, Sm, Rs, RstMov,
        input  mueva, M1, M2, M3, posx, posy, invaded, proto_err
    );

    modport slave (
        input  en, Sm, Rs, RstMov,
        output mueva, M1, M2, M3, posx, posy, invaded, proto_err
    );

endinterface

// File: rtl/invader_move_tracker_tick_prescaler.sv
// Free-running divider producing a registered one-cycle pulse every TICK_DIV
// enabled cycles.
//   clk      in  clock, rising edge
//   rst      in  synchronous active-high reset
//   en_i     in  1 = advance the count; 0 = hold it, no pulse
//   clear_i  in  restart count from 0 and suppress the pulse
//   pulse_o  out one-cycle pulse in the cycle after the count wraps to 0
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clear_i,
    output logic pulse_o
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;
    logic          wrap_c;

    assign wrap_c = (cnt_q == CW'(TICK_DIV - 1));

    // Next count and pulse
    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d   = wrap_c ? '0 : cnt_q + CW'(1);
            pulse_d = wrap_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/invader_move_tracker.sv
// Invader formation tracker: generates the move tick, applies sequencer step
// and leg-complete commands to the step counter and formation position, and
// returns leg-limit flags. Run-control FSM tracks RUN / PAUSE / DONE.
//   CLK  in  clock, rising edge
//   RST  in  synchronous active-high reset
//   bus  slave modport: en/Sm/Rs/RstMov in; mueva, M1..M3, posx, posy,
//        invaded, proto_err out
module invader_move_tracker
    import invader_move_tracker_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST,
    invader_move_tracker_if.slave bus
);

    localparam int unsigned YS_W = Y_W + 1;

    run_state_e       state_q, state_d;
    logic [CNT_W-1:0] movidas_q, movidas_d;
    logic [X_W-1:0]   posx_q, posx_d;
    logic [Y_W-1:0]   posy_q, posy_d;
    logic             invaded_q, invaded_d;
    logic             proto_err_q, proto_err_d;

    move_cmd_t        cmd_c;
    logic [YS_W-1:0]  posy_sum_c;
    logic [Y_W-1:0]   posy_drop_c;
    logic             tick_en_c;
    logic             tick_clr_c;
    logic             tick_pulse;

    assign cmd_c = '{sm: bus.Sm, rs: bus.Rs, rst_mov: bus.RstMov};

    // Row drop with saturation at the top of the y range
    assign posy_sum_c  = {1'b0, posy_q} + YS_W'(DROP);
    assign posy_drop_c = posy_sum_c[Y_W] ? {Y_W{1'b1}} : posy_sum_c[Y_W-1:0];

    // Command decode: RstMov dominates, Sm+Rs together is a no-op error
    always_comb begin
        movidas_d   = movidas_q;
        posx_d      = posx_q;
        posy_d      = posy_q;
        proto_err_d = proto_err_q;

        if (cmd_c.rst_mov) begin
            movidas_d = '0;
            posy_d    = posy_drop_c;
            if (cmd_c.sm || cmd_c.rs) begin
                proto_err_d = 1'b1;
            end
        end else if (cmd_c.sm && cmd_c.rs) begin
            proto_err_d = 1'b1;
        end else if (cmd_c.sm) begin
            movidas_d = cnt_sat_inc(movidas_q);
            if (posx_q < X_W'(X_MAX)) begin
                posx_d = posx_q + X_W'(1);
            end
        end else if (cmd_c.rs) begin
            movidas_d = cnt_sat_inc(movidas_q);
            if (posx_q > X_W'(X_MIN)) begin
                posx_d = posx_q - X_W'(1);
            end
        end

        // Formation is frozen once it has reached the ground
        if (invaded_q) begin
            posx_d = posx_q;
            posy_d = posy_q;
        end

        invaded_d = invaded_q | (posy_d >= Y_W'(Y_LIMIT));
    end

    // Run-control next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (!bus.en) state_d = ST_PAUSE;
            ST_PAUSE: if (bus.en)  state_d = ST_RUN;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_RUN;
        endcase
        if (invaded_d) begin
            state_d = ST_DONE;
        end
    end

    // Tick stops in the same edge the invasion is registered, so no stray pulse
    assign tick_clr_c = (state_d == ST_DONE);
    assign tick_en_c  = bus.en && !tick_clr_c;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (CLK),
        .rst     (RST),
        .en_i    (tick_en_c),
        .clear_i (tick_clr_c),
        .pulse_o (tick_pulse)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_RUN;
            movidas_q   <= '0;
            posx_q      <= X_W'(X_START);
            posy_q      <= Y_W'(Y_START);
            invaded_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            movidas_q   <= movidas_d;
            posx_q      <= posx_d;
            posy_q      <= posy_d;
            invaded_q   <= invaded_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Leg flags compare the registered counter directly
    assign bus.M1        = (movidas_q >= CNT_W'(LIM1));
    assign bus.M2        = (movidas_q >= CNT_W'(LIM2));
    assign bus.M3        = (movidas_q >= CNT_W'(LIM3));
    assign bus.mueva     = tick_pulse;
    assign bus.posx      = posx_q;
    assign bus.posy      = posy_q;
    assign bus.invaded   = invaded_q;
    assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_invader_move_tracker.sv
// Directed bench for invader_move_tracker with a 4-cycle move tick.
module tb_invader_move_tracker;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    invader_move_tracker_if bus ();

    invader_move_tracker #(
        .TICK_DIV (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_cmd(input logic sm, input logic rs, input logic rm);
        bus.Sm     = sm;
        bus.Rs     = rs;
        bus.RstMov = rm;
    endtask

    task automatic do_reset();
        RST    = 1'b1;
        bus.en = 1'b0;
        set_cmd(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        RST = 1'b0;
    endtask

    int unsigned pulses;

    initial begin
        bus.en = 1'b0;
        set_cmd(1'b0, 1'b0, 1'b0);

        // Reset values, then tick cadence
        do_reset();
        check("rst_mueva",   32'(bus.mueva), 0);
        check("rst_posx",    32'(bus.posx), 320);
        check("rst_posy",    32'(bus.posy), 40);
        check("rst_m1",      32'(bus.M1), 0);
        check("rst_invaded", 32'(bus.invaded), 0);
        check("rst_proto",   32'(bus.proto_err), 0);
        bus.en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("t1_mueva_c%0d", k), 32'(bus.mueva), 32'(k % 4 == 0));
        end
        check("t1_posx", 32'(bus.posx), 320);
        check("t1_posy", 32'(bus.posy), 40);

        // Pause holds the prescaler count
        tick();
        tick();
        bus.en = 1'b0;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            pulses += 32'(bus.mueva);
        end
        check("pause_pulses", pulses, 0);
        bus.en = 1'b1;
        tick();
        check("resume_c3", 32'(bus.mueva), 0);
        tick();
        check("resume_c4", 32'(bus.mueva), 1);

        // Leg 1: 250 left steps
        do_reset();
        set_cmd(1'b0, 1'b1, 1'b0);
        repeat (249) tick();
        check("t2_m1_249", 32'(bus.M1), 0);
        tick();
        check("t2_m1_250", 32'(bus.M1), 1);
        check("t2_m2_250", 32'(bus.M2), 0);
        check("t2_m3_250", 32'(bus.M3), 1);
        check("t2_posx",   32'(bus.posx), 70);

        // Leg complete, then RstMov with Sm
        set_cmd(1'b0, 1'b0, 1'b1);
        tick();
        set_cmd(1'b0, 1'b0, 1'b0);
        check("t4_m1",    32'(bus.M1), 0);
        check("t4_m3",    32'(bus.M3), 0);
        check("t4_posy",  32'(bus.posy), 56);
        check("t4_proto0", 32'(bus.proto_err), 0);
        set_cmd(1'b1, 1'b0, 1'b1);
        tick();
        set_cmd(1'b0, 1'b0, 1'b0);
        check("t4_posx",  32'(bus.posx), 70);
        check("t4_posy2", 32'(bus.posy), 72);
        check("t4_proto1", 32'(bus.proto_err), 1);

        // Sm and Rs together: no movement, error flagged
        do_reset();
        set_cmd(1'b1, 1'b1, 1'b0);
        tick();
        set_cmd(1'b0, 1'b0, 1'b0);
        check("both_posx",  32'(bus.posx), 320);
        check("both_proto", 32'(bus.proto_err), 1);

        // Leg 2: right to the bound, counter keeps counting and saturates
        do_reset();
        set_cmd(1'b1, 1'b0, 1'b0);
        repeat (280) tick();
        check("t3_posx600", 32'(bus.posx), 600);
        set_cmd(1'b0, 1'b0, 1'b1);
        tick();
        set_cmd(1'b1, 1'b0, 1'b0);
        repeat (299) tick();
        check("t3_m2_299",  32'(bus.M2), 0);
        check("t3_posx639", 32'(bus.posx), 639);
        tick();
        check("t3_m2_300",  32'(bus.M2), 1);
        repeat (50) tick();
        check("t3_m2_350",  32'(bus.M2), 1);
        check("t3_posx350", 32'(bus.posx), 639);
        repeat (200) tick();
        set_cmd(1'b0, 1'b0, 1'b0);
        check("t3_m1_sat",  32'(bus.M1), 1);
        check("t3_m2_sat",  32'(bus.M2), 1);

        // Left bound
        do_reset();
        set_cmd(1'b0, 1'b1, 1'b0);
        repeat (330) tick();
        check("xmin_posx", 32'(bus.posx), 0);
        set_cmd(1'b1, 1'b0, 1'b0);
        tick();
        set_cmd(1'b0, 1'b0, 1'b0);
        check("xmin_step", 32'(bus.posx), 1);

        // Invasion after 23 drops
        do_reset();
        bus.en = 1'b1;
        set_cmd(1'b0, 1'b0, 1'b1);
        repeat (22) tick();
        check("t5_posy392", 32'(bus.posy), 392);
        check("t5_inv0",    32'(bus.invaded), 0);
        tick();
        check("t5_posy408", 32'(bus.posy), 408);
        check("t5_inv1",    32'(bus.invaded), 1);
        set_cmd(1'b1, 1'b0, 1'b0);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            pulses += 32'(bus.mueva);
        end
        set_cmd(1'b0, 1'b0, 1'b0);
        check("t5_pulses", pulses, 0);
        check("t5_posx",   32'(bus.posx), 320);
        check("t5_posy",   32'(bus.posy), 408);
        check("t5_inv",    32'(bus.invaded), 1);

        // Mid-run reset
        do_reset();
        bus.en = 1'b1;
        set_cmd(1'b0, 1'b1, 1'b0);
        repeat (220) tick();
        set_cmd(1'b1, 1'b1, 1'b0);
        tick();
        set_cmd(1'b0, 1'b0, 1'b0);
        check("t6_posx100", 32'(bus.posx), 100);
        check("t6_proto1",  32'(bus.proto_err), 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("t6_posx",  32'(bus.posx), 320);
        check("t6_posy",  32'(bus.posy), 40);
        check("t6_mueva", 32'(bus.mueva), 0);
        check("t6_m1",    32'(bus.M1), 0);
        check("t6_inv",   32'(bus.invaded), 0);
        check("t6_proto", 32'(bus.proto_err), 0);
        bus.en = 1'b0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            pulses += 32'(bus.mueva);
        end
        check("t6_pause_pulses", pulses, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
